// File: rtl/reorder_buffer_mc.sv
// Multi-commit, multi-writeback reorder buffer: in-order retirement of up to
// COMMIT_WIDTH entries per cycle, registered flush on mispredict or exception.
module reorder_buffer_mc #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int COMMIT_WIDTH = 2,
    parameter int WB_PORTS     = 3,
    parameter int Q_PORTS      = 2,
    parameter int TYPE_BIT     = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              rdy_in,
    input  logic                              alloc_valid,
    input  logic                              alloc_done,
    input  logic [TYPE_BIT-1:0]               alloc_type,
    input  logic [4:0]                        alloc_rd,
    input  logic [31:0]                       alloc_value,
    input  logic [31:0]                       alloc_jump,
    output logic [ROB_SIZE_BIT-1:0]           alloc_id,
    output logic [ROB_SIZE_BIT-1:0]           head_id,
    output logic                              full,
    output logic                              empty,
    output logic [ROB_SIZE_BIT:0]             count,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*ROB_SIZE_BIT-1:0]  wb_id,
    input  logic [WB_PORTS*32-1:0]            wb_value,
    input  logic [Q_PORTS*ROB_SIZE_BIT-1:0]   q_id,
    output logic [Q_PORTS-1:0]                q_ready,
    output logic [Q_PORTS*32-1:0]             q_value,
    output logic [COMMIT_WIDTH-1:0]           commit_valid,
    output logic [COMMIT_WIDTH*5-1:0]         commit_rd,
    output logic [COMMIT_WIDTH*32-1:0]        commit_value,
    output logic [COMMIT_WIDTH*ROB_SIZE_BIT-1:0] commit_id,
    output logic                              flush,
    output logic [31:0]                       flush_pc,
    output logic [15:0]                       retired
);
    localparam int RSB      = ROB_SIZE_BIT;
    localparam int ROB_SIZE = 1 << ROB_SIZE_BIT;
    localparam logic [TYPE_BIT-1:0] TYPE_RG = TYPE_BIT'(0);
    localparam logic [TYPE_BIT-1:0] TYPE_BR = TYPE_BIT'(2);
    localparam logic [TYPE_BIT-1:0] TYPE_EX = TYPE_BIT'(3);

    logic                busy  [ROB_SIZE];
    logic                ready [ROB_SIZE];
    logic [TYPE_BIT-1:0] etype [ROB_SIZE];
    logic [4:0]          erd   [ROB_SIZE];
    logic [31:0]         evalue[ROB_SIZE];
    logic [31:0]         ejump [ROB_SIZE];

    logic [RSB-1:0] head, tail;
    logic [RSB:0]   n_ret;
    logic [ROB_SIZE-1:0] retire_mask;
    logic           redirect;
    logic [31:0]    redirect_pc;
    logic           alloc_ok;
    logic           stop;
    logic [RSB-1:0] idx;

    assign alloc_id = tail;
    assign head_id  = head;
    assign full     = (count == (RSB+1)'(ROB_SIZE));
    assign empty    = (count == '0);
    assign alloc_ok = rdy_in && !flush && alloc_valid && !full;

    // Commit scan: stops at the first non-retirable slot or after a redirecting entry.
    always_comb begin
        commit_valid = '0;
        commit_rd    = '0;
        commit_value = '0;
        commit_id    = '0;
        retire_mask  = '0;
        n_ret        = '0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        idx          = '0;
        stop         = !rdy_in || flush;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            idx = head + RSB'(k);
            if (!stop && busy[idx] && ready[idx] && (32'(count) > k)) begin
                retire_mask[idx]          = 1'b1;
                n_ret                     = n_ret + (RSB+1)'(1);
                commit_id[k*RSB +: RSB]   = idx;
                if (etype[idx] == TYPE_RG) begin
                    commit_valid[k]         = 1'b1;
                    commit_rd[k*5 +: 5]     = erd[idx];
                    commit_value[k*32 +: 32] = evalue[idx];
                end else if (etype[idx] == TYPE_BR) begin
                    if (evalue[idx][0] ^ ejump[idx][0]) begin
                        redirect    = 1'b1;
                        redirect_pc = {ejump[idx][31:1], 1'b0};
                        stop        = 1'b1;
                    end
                end else if (etype[idx] == TYPE_EX) begin
                    redirect    = 1'b1;
                    redirect_pc = ejump[idx];
                    stop        = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Stored value takes precedence over a same-cycle writeback forward.
    always_comb begin
        q_ready = '0;
        q_value = '0;
        for (int unsigned j = 0; j < Q_PORTS; j++) begin
            if (ready[q_id[j*RSB +: RSB]]) begin
                q_ready[j]          = 1'b1;
                q_value[j*32 +: 32] = evalue[q_id[j*RSB +: RSB]];
            end else begin
                for (int unsigned p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && (wb_id[p*RSB +: RSB] == q_id[j*RSB +: RSB])) begin
                        q_ready[j]          = 1'b1;
                        q_value[j*32 +: 32] = wb_value[p*32 +: 32];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                busy[i]  <= 1'b0;
                ready[i] <= 1'b0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
            retired  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    busy[i]  <= 1'b0;
                    ready[i] <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
                flush <= 1'b0;
            end else begin
                // Ascending port order lets the highest port win on a shared id.
                for (int unsigned p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && busy[wb_id[p*RSB +: RSB]] && !retire_mask[wb_id[p*RSB +: RSB]]) begin
                        ready[wb_id[p*RSB +: RSB]]  <= 1'b1;
                        evalue[wb_id[p*RSB +: RSB]] <= wb_value[p*32 +: 32];
                    end
                end
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    if (retire_mask[i]) begin
                        busy[i]  <= 1'b0;
                        ready[i] <= 1'b0;
                    end
                end
                if (alloc_ok) begin
                    busy[tail]   <= 1'b1;
                    ready[tail]  <= alloc_done;
                    etype[tail]  <= alloc_type;
                    erd[tail]    <= alloc_rd;
                    evalue[tail] <= alloc_value;
                    ejump[tail]  <= alloc_jump;
                    tail         <= tail + RSB'(1);
                end
                head    <= head + n_ret[RSB-1:0];
                count   <= count + (RSB+1)'(alloc_ok) - n_ret;
                retired <= retired + 16'(n_ret);
                flush   <= redirect;
                if (redirect) flush_pc <= redirect_pc;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc with hand-computed expectations.
module tb_reorder_buffer_mc;
    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in;
    logic        alloc_valid, alloc_done;
    logic [1:0]  alloc_type;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_value, alloc_jump;
    logic [3:0]  alloc_id, head_id;
    logic        full, empty;
    logic [4:0]  count;
    logic [2:0]  wb_valid;
    logic [11:0] wb_id;
    logic [95:0] wb_value;
    logic [7:0]  q_id;
    logic [1:0]  q_ready;
    logic [63:0] q_value;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_rd;
    logic [63:0] commit_value;
    logic [7:0]  commit_id;
    logic        flush;
    logic [31:0] flush_pc;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    reorder_buffer_mc #(.ROB_SIZE_BIT(4), .COMMIT_WIDTH(2), .WB_PORTS(3), .Q_PORTS(2), .TYPE_BIT(2)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_done(alloc_done), .alloc_type(alloc_type),
        .alloc_rd(alloc_rd), .alloc_value(alloc_value), .alloc_jump(alloc_jump),
        .alloc_id(alloc_id), .head_id(head_id), .full(full), .empty(empty), .count(count),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
        .q_id(q_id), .q_ready(q_ready), .q_value(q_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_id(commit_id), .flush(flush), .flush_pc(flush_pc), .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_done = 0; alloc_type = 0; alloc_rd = 0;
        alloc_value = 0; alloc_jump = 0;
        wb_valid = 0; wb_id = 0; wb_value = 0;
    endtask

    task automatic do_alloc(input logic [1:0] t, input logic [4:0] r, input logic [31:0] v,
                            input logic [31:0] j, input logic d);
        alloc_valid = 1; alloc_type = t; alloc_rd = r;
        alloc_value = v; alloc_jump = j; alloc_done = d;
    endtask

    task automatic do_wb(input int p, input logic [3:0] id, input logic [31:0] v);
        wb_valid[p] = 1'b1;
        wb_id[p*4 +: 4] = id;
        wb_value[p*32 +: 32] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_in = 0; rdy_in = 1; q_id = 0; idle();
        tick(); tick();
        rst_n_in = 1; #1;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_alloc_id", 32'(alloc_id), 0);

        // Dual commit: head waits for a writeback while two done entries queue behind it
        do_alloc(2'd0, 5'd1, 0, 0, 0); #1;
        chk("t1_alloc_id", 32'(alloc_id), 0);
        tick(); idle();
        do_alloc(2'd0, 5'd2, 20, 0, 1); tick(); idle();
        do_alloc(2'd0, 5'd3, 30, 0, 1); do_wb(0, 4'd0, 10); #1;
        chk("t1_no_commit", 32'(commit_valid), 0);
        tick(); idle(); #1;
        chk("t1_count3", 32'(count), 3);
        chk("t1_cv2", 32'(commit_valid), 3);
        chk("t1_rd", 32'(commit_rd), 32'h41);
        chk("t1_val0", commit_value[31:0], 10);
        chk("t1_val1", commit_value[63:32], 20);
        chk("t1_id", 32'(commit_id), 32'h10);
        tick(); #1;
        chk("t1_cv1", 32'(commit_valid), 1);
        chk("t1_rd3", 32'(commit_rd[4:0]), 3);
        chk("t1_val3", commit_value[31:0], 30);
        tick(); #1;
        chk("t1_empty", 32'(empty), 1);
        chk("t1_retired", 32'(retired), 3);
        chk("t1_head", 32'(head_id), 3);

        // Same-id writeback on ports 0 and 2; operand query forwarding
        do_alloc(2'd0, 5'd5, 0, 0, 0); tick(); idle();
        do_wb(0, 4'd3, 32'h11); do_wb(2, 4'd3, 32'h22); q_id = {4'd4, 4'd3}; #1;
        chk("t3_q_ready", 32'(q_ready), 1);
        chk("t3_q_fwd", q_value[31:0], 32'h22);
        chk("t3_q_zero", q_value[63:32], 0);
        chk("t3_no_commit", 32'(commit_valid), 0);
        tick(); idle(); q_id = {4'd3, 4'd3}; #1;
        chk("t3_q_stored_rdy", 32'(q_ready), 3);
        chk("t3_q_stored", q_value[63:32], 32'h22);
        chk("t3_commit_val", commit_value[31:0], 32'h22);
        chk("t3_commit_rd", 32'(commit_rd[4:0]), 5);
        tick(); #1;
        chk("t3_retired", 32'(retired), 4);

        // Mispredicted branch retires alone, then flush
        do_alloc(2'd2, 5'd0, 1, 32'h100, 0); tick(); idle();
        do_alloc(2'd0, 5'd7, 77, 0, 1); tick(); idle();
        do_wb(1, 4'd4, 1); tick(); idle(); #1;
        chk("t4_br_silent", 32'(commit_valid), 0);
        chk("t4_count2", 32'(count), 2);
        tick(); #1;
        chk("t4_flush", 32'(flush), 1);
        chk("t4_flush_pc", flush_pc, 32'h100);
        chk("t4_count1", 32'(count), 1);
        chk("t4_cv_in_flush", 32'(commit_valid), 0);
        tick(); #1;
        chk("t4_flush_off", 32'(flush), 0);
        chk("t4_empty", 32'(empty), 1);
        chk("t4_tail0", 32'(alloc_id), 0);
        chk("t4_head0", 32'(head_id), 0);
        chk("t4_pc_hold", flush_pc, 32'h100);
        chk("t4_retired", 32'(retired), 5);

        // Fill to full; extra alloc dropped; head writeback frees one slot
        for (int i = 0; i < 16; i++) begin
            do_alloc(2'd0, 5'(i + 1), 0, 0, 0); tick(); idle();
        end
        #1;
        chk("t2_full", 32'(full), 1);
        chk("t2_count16", 32'(count), 16);
        do_alloc(2'd0, 5'd31, 32'hDEAD, 0, 1); tick(); idle(); #1;
        chk("t2_drop_count", 32'(count), 16);
        chk("t2_drop_cv", 32'(commit_valid), 0);
        do_wb(0, 4'd0, 32'hAB); tick(); idle(); #1;
        chk("t2_cv", 32'(commit_valid), 1);
        chk("t2_val", commit_value[31:0], 32'hAB);
        tick(); #1;
        chk("t2_count15", 32'(count), 15);
        chk("t2_not_full", 32'(full), 0);
        chk("t2_retired", 32'(retired), 6);
        rst_n_in = 0; tick(); rst_n_in = 1; #1;
        chk("t2_reset_empty", 32'(empty), 1);

        // Wrap: one alloc and one commit per cycle across index 15->0
        for (int i = 0; i <= 20; i++) begin
            idle();
            if (i < 20) do_alloc(2'd0, 5'((i % 31) + 1), 32'(100 + i), 0, 1);
            #1;
            if (i > 0) begin
                chk("t5_cv", 32'(commit_valid), 1);
                chk("t5_val", commit_value[31:0], 32'(100 + i - 1));
                chk("t5_id", 32'(commit_id[3:0]), 32'((i - 1) % 16));
            end
            tick();
        end
        idle(); #1;
        chk("t5_retired", 32'(retired), 20);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_head", 32'(head_id), 4);

        // Pause holds state; reset overrides a pending exception flush
        do_alloc(2'd0, 5'd9, 99, 0, 1); tick(); idle();
        rdy_in = 0; #1;
        chk("t6_paused_cv", 32'(commit_valid), 0);
        tick(); #1;
        chk("t6_paused_count", 32'(count), 1);
        do_alloc(2'd0, 5'd10, 1, 0, 1); tick(); idle(); #1;
        chk("t6_paused_drop", 32'(count), 1);
        rdy_in = 1; #1;
        chk("t6_resume_cv", 32'(commit_valid), 1);
        chk("t6_resume_val", commit_value[31:0], 99);
        tick();
        do_alloc(2'd3, 5'd0, 0, 32'h200, 1); tick(); idle(); #1;
        chk("t6_ex_silent", 32'(commit_valid), 0);
        rst_n_in = 0; tick(); rst_n_in = 1; #1;
        chk("t6_rst_flush", 32'(flush), 0);
        chk("t6_rst_pc", flush_pc, 0);
        chk("t6_rst_empty", 32'(empty), 1);
        chk("t6_rst_retired", 32'(retired), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
